// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: hex font, segment bit
// positions and the width helper for the PWM on-time comparison.
package sseg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int DP_BIT = 7;

    // Active-high g..a patterns for hex digits 0..F
    localparam logic [6:0] FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Wide enough to hold (2**bright_bits) * prescale without losing bits before the shift
    function automatic int on_time_width(input int prescale, input int bright_bits);
        return $clog2(prescale) + bright_bits + 1;
    endfunction

endpackage

// File: rtl/sseg_hex_font.sv
// Combinational hex-nibble to seven-segment decoder (active-high, g..a).
module sseg_hex_font (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    import sseg_pkg::*;

    assign seg = FONT[nibble];

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed seven-segment driver with frame-synchronous input latching,
// PWM brightness, blanking, decimal points and leading-zero suppression.
module sseg_scan_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE       = 16384,
    parameter int BRIGHT_BITS    = 3,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    output logic [7:0]              sseg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);
    import sseg_pkg::*;

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int OT_W  = on_time_width(PRESCALE, BRIGHT_BITS);

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                      : {NUM_DIGITS{1'b0}};

    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;
    logic                   started;
    logic                   load;

    logic [4*NUM_DIGITS-1:0] data_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic [NUM_DIGITS-1:0]   blank_sh;
    logic                    lz_sh;
    logic [BRIGHT_BITS-1:0]  bright_sh;

    logic [OT_W-1:0]        on_time;
    logic                   in_window;
    logic [3:0]             cur_nibble;
    logic                   cur_dp;
    logic                   cur_blank;
    logic                   cur_supp;
    logic                   lit;
    logic [6:0]             font_seg;
    logic [7:0]             seg_next;
    logic [NUM_DIGITS-1:0]  an_next;

    // The first edge after reset is a restart edge: it latches a fresh frame
    // and holds the scan at digit 0, slot 0, just like a normal frame boundary.
    assign load = !started || (cnt == CNT_LAST && idx == IDX_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            idx     <= '0;
            started <= 1'b0;
        end else if (!started) begin
            cnt     <= '0;
            idx     <= '0;
            started <= 1'b1;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_sh     <= '0;
            dp_sh       <= '0;
            blank_sh    <= '1;
            lz_sh       <= 1'b0;
            bright_sh   <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= load;
            if (load) begin
                data_sh   <= data;
                dp_sh     <= dp;
                blank_sh  <= blank;
                lz_sh     <= lz_suppress;
                bright_sh <= brightness;
            end
        end
    end

    // Slot 0 is always dark so the previous digit's segments never ghost onto the next anode
    assign on_time   = ((OT_W'(bright_sh) + OT_W'(1)) * OT_W'(PRESCALE)) >> BRIGHT_BITS;
    assign in_window = (cnt != '0) && (OT_W'(cnt) < on_time);

    always_comb begin
        logic run;
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b1;
        cur_supp   = 1'b0;
        run        = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run = run && (data_sh[4*i +: 4] == 4'h0);
            if (idx == IDX_W'(i)) begin
                cur_nibble = data_sh[4*i +: 4];
                cur_dp     = dp_sh[i];
                cur_blank  = blank_sh[i];
                cur_supp   = (i > 0) && lz_sh && run;
            end
        end
    end

    sseg_hex_font u_font (
        .nibble (cur_nibble),
        .seg    (font_seg)
    );

    assign lit = in_window && !cur_blank;

    always_comb begin
        seg_next = 8'h00;
        an_next  = '0;
        if (lit) begin
            seg_next[SEG_G:SEG_A] = cur_supp ? 7'h00 : font_seg;
            seg_next[DP_BIT]      = cur_dp;
            an_next               = NUM_DIGITS'(1) << idx;
        end
    end

    // XOR with the inactive pattern applies the output polarity in one step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an   <= AN_OFF;
            sseg <= SEG_OFF;
        end else begin
            an   <= an_next ^ AN_OFF;
            sseg <= seg_next ^ SEG_OFF;
        end
    end

endmodule
